// File: rtl/vram1_access_pkg.sv
// -----------------------------------------------------------------------------
// vram1_access_pkg
//   Shared constants and the controller state encoding for the VRAM1 access
//   controller (4096 x 16 tilemap RAM built from two byte-wide SRAMs).
// -----------------------------------------------------------------------------
package vram1_access_pkg;

  localparam int unsigned VRAM1_ADDR_W = 12;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned BYTE_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VID_RD  = 3'd1,
    ST_VID_CAP = 3'd2,
    ST_CPU_WR  = 3'd3,
    ST_CPU_RD  = 3'd4,
    ST_CPU_CAP = 3'd5,
    ST_CPU_ACK = 3'd6
  } state_e;

endpackage

// File: rtl/vram1_access_ctrl.sv
// -----------------------------------------------------------------------------
// vram1_access_ctrl
//   Arbitrates the CPU bus and the video tilemap fetcher onto the VRAM1 SRAM
//   pair. Video fetches win over new CPU cycles; a video request that arrives
//   while the RAM is busy is parked in a one-deep pending slot.
//
// Ports
//   i_MCLK, i_RST_n            clock, synchronous active-low reset
//   i_CPU_CS_n/RW/UDS_n/LDS_n  CPU bus cycle control (CS held for whole cycle)
//   i_CPU_ADDR, i_CPU_DIN      CPU word address and write data
//   o_CPU_DOUT, o_CPU_DTACK_n  CPU read data and acknowledge
//   i_VID_REQ, i_VID_ADDR      one-cycle tilemap fetch request
//   o_VID_DATA, o_VID_VALID    fetched word with one-cycle qualifier
//   o_VID_OVF                  sticky flag: a pending request was overwritten
//   o_RAM_*                    shared address/data/read strobe, per-byte writes
//   i_RAM_LO/HI_DOUT           SRAM registered read data (one-cycle latency)
// -----------------------------------------------------------------------------
module vram1_access_ctrl
  import vram1_access_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM1_ADDR_W
) (
  input  logic              i_MCLK,
  input  logic              i_RST_n,
  input  logic              i_CPU_CS_n,
  input  logic              i_CPU_RW,
  input  logic              i_CPU_UDS_n,
  input  logic              i_CPU_LDS_n,
  input  logic [ADDR_W-1:0] i_CPU_ADDR,
  input  logic [DATA_W-1:0] i_CPU_DIN,
  output logic [DATA_W-1:0] o_CPU_DOUT,
  output logic              o_CPU_DTACK_n,
  input  logic              i_VID_REQ,
  input  logic [ADDR_W-1:0] i_VID_ADDR,
  output logic [DATA_W-1:0] o_VID_DATA,
  output logic              o_VID_VALID,
  output logic              o_VID_OVF,
  output logic [ADDR_W-1:0] o_RAM_ADDR,
  output logic [DATA_W-1:0] o_RAM_DIN,
  output logic              o_RAM_RD_n,
  output logic              o_RAM_LO_WR_n,
  output logic              o_RAM_HI_WR_n,
  input  logic [BYTE_W-1:0] i_RAM_LO_DOUT,
  input  logic [BYTE_W-1:0] i_RAM_HI_DOUT
);

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                rd_n_q, rd_n_d;
  logic                lo_wr_n_q, lo_wr_n_d;
  logic                hi_wr_n_q, hi_wr_n_d;
  logic                dtack_n_q, dtack_n_d;
  logic [DATA_W-1:0]   cpu_dout_q, cpu_dout_d;
  logic [DATA_W-1:0]   vid_data_q, vid_data_d;
  logic                vid_valid_q, vid_valid_d;
  logic                cpu_new;

  // done stops a CPU cycle that is still selected after its acknowledge from
  // being serviced twice; it only clears once the CPU drops CS.
  assign cpu_new = ~i_CPU_CS_n & ~done_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rd_n_d      = 1'b1;
    lo_wr_n_d   = 1'b1;
    hi_wr_n_d   = 1'b1;
    dtack_n_d   = dtack_n_q;
    cpu_dout_d  = cpu_dout_q;
    vid_data_d  = vid_data_q;
    vid_valid_d = 1'b0;

    if (i_CPU_CS_n) begin
      done_d = 1'b0;
    end

    if (i_VID_REQ && (state_q != ST_IDLE)) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end
      pend_d      = 1'b1;
      pend_addr_d = i_VID_ADDR;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // Serve the parked request; a fresh request in the same cycle takes
          // over the slot being vacated, so it is not counted as an overflow.
          ram_addr_d = pend_addr_q;
          rd_n_d     = 1'b0;
          state_d    = ST_VID_RD;
          if (i_VID_REQ) begin
            pend_d      = 1'b1;
            pend_addr_d = i_VID_ADDR;
          end else begin
            pend_d = 1'b0;
          end
        end else if (i_VID_REQ) begin
          ram_addr_d = i_VID_ADDR;
          rd_n_d     = 1'b0;
          state_d    = ST_VID_RD;
        end else if (cpu_new) begin
          ram_addr_d = i_CPU_ADDR;
          if (i_CPU_RW) begin
            rd_n_d  = 1'b0;
            state_d = ST_CPU_RD;
          end else begin
            ram_din_d = i_CPU_DIN;
            lo_wr_n_d = i_CPU_LDS_n;
            hi_wr_n_d = i_CPU_UDS_n;
            state_d   = ST_CPU_WR;
          end
        end
      end

      ST_VID_RD: begin
        state_d = ST_VID_CAP;
      end

      ST_VID_CAP: begin
        vid_data_d  = {i_RAM_HI_DOUT, i_RAM_LO_DOUT};
        vid_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_CPU_WR: begin
        dtack_n_d = 1'b0;
        done_d    = 1'b1;
        state_d   = ST_CPU_ACK;
      end

      ST_CPU_RD: begin
        state_d = ST_CPU_CAP;
      end

      ST_CPU_CAP: begin
        cpu_dout_d = {i_RAM_HI_DOUT, i_RAM_LO_DOUT};
        dtack_n_d  = 1'b0;
        done_d     = 1'b1;
        state_d    = ST_CPU_ACK;
      end

      ST_CPU_ACK: begin
        if (i_CPU_CS_n) begin
          dtack_n_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_MCLK) begin
    if (!i_RST_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rd_n_q      <= 1'b1;
      lo_wr_n_q   <= 1'b1;
      hi_wr_n_q   <= 1'b1;
      dtack_n_q   <= 1'b1;
      cpu_dout_q  <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rd_n_q      <= rd_n_d;
      lo_wr_n_q   <= lo_wr_n_d;
      hi_wr_n_q   <= hi_wr_n_d;
      dtack_n_q   <= dtack_n_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
    end
  end

  assign o_CPU_DOUT    = cpu_dout_q;
  assign o_CPU_DTACK_n = dtack_n_q;
  assign o_VID_DATA    = vid_data_q;
  assign o_VID_VALID   = vid_valid_q;
  assign o_VID_OVF     = ovf_q;
  assign o_RAM_ADDR    = ram_addr_q;
  assign o_RAM_DIN     = ram_din_q;
  assign o_RAM_RD_n    = rd_n_q;
  assign o_RAM_LO_WR_n = lo_wr_n_q;
  assign o_RAM_HI_WR_n = hi_wr_n_q;

endmodule

// File: tb/tb_vram1_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vram1_access_ctrl
//   Directed bench for vram1_access_ctrl with byte-wide SRAM models behind the
//   RAM ports and scoreboards for video fetches and CPU reads.
// -----------------------------------------------------------------------------
module tb_vram1_access_ctrl;
  import vram1_access_pkg::*;

  localparam int unsigned AW = 12;

  logic          clk;
  logic          rst_n;
  logic          cpu_cs_n, cpu_rw, cpu_uds_n, cpu_lds_n;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic [15:0]   cpu_dout;
  logic          cpu_dtack_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_data;
  logic          vid_valid, vid_ovf;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic          ram_rd_n, ram_lo_wr_n, ram_hi_wr_n;
  logic [7:0]    ram_lo_dout = 8'h00;
  logic [7:0]    ram_hi_dout = 8'h00;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [15:0] vq[$];
  logic [15:0] cq[$];

  logic [7:0] lo_mem [0:(1<<AW)-1];
  logic [7:0] hi_mem [0:(1<<AW)-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vram1_access_ctrl #(.ADDR_W(AW)) dut (
    .i_MCLK        (clk),
    .i_RST_n       (rst_n),
    .i_CPU_CS_n    (cpu_cs_n),
    .i_CPU_RW      (cpu_rw),
    .i_CPU_UDS_n   (cpu_uds_n),
    .i_CPU_LDS_n   (cpu_lds_n),
    .i_CPU_ADDR    (cpu_addr),
    .i_CPU_DIN     (cpu_din),
    .o_CPU_DOUT    (cpu_dout),
    .o_CPU_DTACK_n (cpu_dtack_n),
    .i_VID_REQ     (vid_req),
    .i_VID_ADDR    (vid_addr),
    .o_VID_DATA    (vid_data),
    .o_VID_VALID   (vid_valid),
    .o_VID_OVF     (vid_ovf),
    .o_RAM_ADDR    (ram_addr),
    .o_RAM_DIN     (ram_din),
    .o_RAM_RD_n    (ram_rd_n),
    .o_RAM_LO_WR_n (ram_lo_wr_n),
    .o_RAM_HI_WR_n (ram_hi_wr_n),
    .i_RAM_LO_DOUT (ram_lo_dout),
    .i_RAM_HI_DOUT (ram_hi_dout)
  );

  // Low-byte and high-byte SRAM models: synchronous write, registered read.
  always @(posedge clk) begin
    if (!ram_lo_wr_n) lo_mem[ram_addr] <= ram_din[7:0];
    if (!ram_rd_n)    ram_lo_dout      <= lo_mem[ram_addr];
  end

  always @(posedge clk) begin
    if (!ram_hi_wr_n) hi_mem[ram_addr] <= ram_din[15:8];
    if (!ram_rd_n)    ram_hi_dout      <= hi_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Video scoreboard consumer and strobe exclusivity monitor.
  always @(negedge clk) begin
    chk("strobe_excl", 32'(!ram_rd_n && (!ram_lo_wr_n || !ram_hi_wr_n)), 32'd0);
    if (vid_valid) begin
      chk("vid_expected", 32'(vq.size() > 0), 32'd1);
      if (vq.size() > 0) chk("vid_data", 32'(vid_data), 32'(vq.pop_front()));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_n"},   32'(ram_rd_n),    32'd1);
    chk({tag, "_lo_wr"},  32'(ram_lo_wr_n), 32'd1);
    chk({tag, "_hi_wr"},  32'(ram_hi_wr_n), 32'd1);
    chk({tag, "_addr"},   32'(ram_addr),    32'd0);
    chk({tag, "_din"},    32'(ram_din),     32'd0);
    chk({tag, "_dtack"},  32'(cpu_dtack_n), 32'd1);
    chk({tag, "_dout"},   32'(cpu_dout),    32'd0);
    chk({tag, "_vdata"},  32'(vid_data),    32'd0);
    chk({tag, "_vvalid"}, 32'(vid_valid),   32'd0);
    chk({tag, "_ovf"},    32'(vid_ovf),     32'd0);
  endtask

  task automatic wait_dtack(input string tag, input logic lvl);
    for (int n = 0; n < 20; n++) begin
      if (cpu_dtack_n === lvl) break;
      tick();
    end
    chk(tag, 32'(cpu_dtack_n), 32'(lvl));
  endtask

  task automatic release_cpu();
    cpu_cs_n  = 1'b1;
    cpu_uds_n = 1'b1;
    cpu_lds_n = 1'b1;
    cpu_rw    = 1'b1;
    tick();
    chk("dtack_release", 32'(cpu_dtack_n), 32'd1);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [15:0] d,
                           input logic uds_n, input logic lds_n);
    cpu_cs_n  = 1'b0;
    cpu_rw    = 1'b0;
    cpu_addr  = a;
    cpu_din   = d;
    cpu_uds_n = uds_n;
    cpu_lds_n = lds_n;
    tick();
    wait_dtack("wr_dtack", 1'b0);
    release_cpu();
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [15:0] exp);
    cq.push_back(exp);
    cpu_cs_n  = 1'b0;
    cpu_rw    = 1'b1;
    cpu_addr  = a;
    cpu_uds_n = 1'b0;
    cpu_lds_n = 1'b0;
    tick();
    wait_dtack("rd_dtack", 1'b0);
    chk("rd_data", 32'(cpu_dout), 32'(cq.pop_front()));
    release_cpu();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      lo_mem[i] = 8'h00;
      hi_mem[i] = 8'h00;
    end
    lo_mem[12'h010] = 8'hEF; hi_mem[12'h010] = 8'hBE;
    lo_mem[12'h020] = 8'h11; hi_mem[12'h020] = 8'h11;
    lo_mem[12'h021] = 8'h22; hi_mem[12'h021] = 8'h22;

    rst_n = 1'b0;
    cpu_cs_n = 1'b1; cpu_rw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_addr = '0; cpu_din = '0; vid_req = 1'b0; vid_addr = '0;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Word write then read back.
    cpu_write(12'h0A5, 16'h1234, 1'b0, 1'b0);
    cpu_read(12'h0A5, 16'h1234);

    // Byte lanes, and a strobe-less cycle that must acknowledge without writing.
    cpu_write(12'h0A5, 16'hFF55, 1'b1, 1'b0);
    cpu_read(12'h0A5, 16'h1255);
    cpu_write(12'h0A5, 16'hAA00, 1'b0, 1'b1);
    cpu_read(12'h0A5, 16'hAA55);
    cpu_write(12'h0A5, 16'h9999, 1'b1, 1'b1);
    cpu_read(12'h0A5, 16'hAA55);

    // Video fetch latency: request sampled at edge k, VALID after edge k+2 only.
    vq.push_back(16'hBEEF);
    vid_req = 1'b1; vid_addr = 12'h010;
    tick();
    vid_req = 1'b0;
    chk("vid_rd_n_k",  32'(ram_rd_n),  32'd0);
    chk("vid_addr_k",  32'(ram_addr),  32'h010);
    tick();
    chk("vid_rd_n_k1", 32'(ram_rd_n),  32'd1);
    chk("vid_valid_k1", 32'(vid_valid), 32'd0);
    tick();
    chk("vid_valid_k2", 32'(vid_valid), 32'd1);
    chk("vid_data_k2",  32'(vid_data),  32'hBEEF);
    tick();
    chk("vid_valid_k3", 32'(vid_valid), 32'd0);

    // Simultaneous new CPU write and video request: video goes first.
    vq.push_back(16'hBEEF);
    cpu_cs_n = 1'b0; cpu_rw = 1'b0; cpu_addr = 12'h0B0; cpu_din = 16'h5A5A;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    vid_req = 1'b1; vid_addr = 12'h010;
    tick();
    vid_req = 1'b0;
    chk("arb_vid_first_rd", 32'(ram_rd_n),    32'd0);
    chk("arb_vid_first_wr", 32'(ram_lo_wr_n), 32'd1);
    wait_dtack("arb_dtack", 1'b0);
    chk("arb_vid_done", 32'(vq.size()), 32'd0);
    release_cpu();
    cpu_read(12'h0B0, 16'h5A5A);

    // Two video requests during one CPU_ACK: only the second is fetched.
    cpu_cs_n = 1'b0; cpu_rw = 1'b0; cpu_addr = 12'h0C0; cpu_din = 16'h0001;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    tick();
    wait_dtack("ovf_dtack", 1'b0);
    vq.push_back(16'h2222);
    vid_req = 1'b1; vid_addr = 12'h020;
    tick();
    chk("ovf_not_yet", 32'(vid_ovf), 32'd0);
    vid_addr = 12'h021;
    tick();
    vid_req = 1'b0;
    chk("ovf_set", 32'(vid_ovf), 32'd1);
    tick(); tick();
    chk("ovf_held_in_ack", 32'(vid_valid), 32'd0);
    release_cpu();
    for (int n = 0; n < 20; n++) begin
      if (vq.size() == 0) break;
      tick();
    end
    tick();
    chk("ovf_fetch_done", 32'(vq.size()), 32'd0);
    cpu_read(12'h0C0, 16'h0001);
    chk("ovf_sticky", 32'(vid_ovf), 32'd1);

    // Reset during CPU_WR; the still-selected cycle is serviced afterwards.
    cpu_cs_n = 1'b0; cpu_rw = 1'b0; cpu_addr = 12'h0D0; cpu_din = 16'h7777;
    cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    tick();
    chk("wr_strobe_k", 32'(ram_lo_wr_n), 32'd0);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst_wr");
    rst_n = 1'b1;
    tick();
    wait_dtack("post_rst_dtack", 1'b0);
    release_cpu();

    // Reset during VID_RD: no VALID may follow.
    vid_req = 1'b1; vid_addr = 12'h010;
    tick();
    vid_req = 1'b0;
    chk("vid_rd_before_rst", 32'(ram_rd_n), 32'd0);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("rst_vid");
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("no_valid_after_rst", 32'(vid_valid), 32'd0);
    end

    chk("vid_q_empty", 32'(vq.size()), 32'd0);
    chk("cpu_q_empty", 32'(cq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
